// File: rtl/core_pkg.sv
// Shared encodings for the MEM stage: load types, response-FSM states, forward-bus width.
package core_pkg;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_BU = 3'd2;
  localparam logic [2:0] LD_H  = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

  localparam int MS_FWD_BUS_W = 39;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_HOLD = 2'd2
  } ms_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic        res_from_mem;
    logic [2:0]  load_op;
    logic        gr_we;
    logic [4:0]  dest;
  } ms_payload_t;

endpackage

// File: rtl/mem_load_align.sv
// Combinational load alignment: picks the byte/half lane from the read word and extends it.
module mem_load_align
  import core_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  load_op,
  output logic [31:0] result
);

  logic [7:0]  byte_d;
  logic [15:0] half_d;

  always_comb begin
    case (addr)
      2'd0:    byte_d = rdata[7:0];
      2'd1:    byte_d = rdata[15:8];
      2'd2:    byte_d = rdata[23:16];
      default: byte_d = rdata[31:24];
    endcase
    half_d = addr[1] ? rdata[31:16] : rdata[15:0];

    case (load_op)
      LD_B:    result = {{24{byte_d[7]}}, byte_d};
      LD_BU:   result = {24'd0, byte_d};
      LD_H:    result = {{16{half_d[15]}}, half_d};
      LD_HU:   result = {16'd0, half_d};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data-SRAM response, aligns load data, hands off to WB.
// Optional macro MS_FWD_EN drives ms_fwd_bus for ID bypass; otherwise the bus is tied to 0.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  MS_IDLE | no response outstanding; instr (if any) is ready
//  MS_WAIT | memory op in MEM, response not yet seen; rdata used live
//  MS_HOLD | response captured in hold_data while WB stalls
module mem_stage
  import core_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    es2ms_valid,
  output logic                    ms_allowin,
  input  logic [31:0]             es_pc,
  input  logic [31:0]             es_alu_result,
  input  logic                    es_res_from_mem,
  input  logic                    es_mem_req,
  input  logic [2:0]              es_load_op,
  input  logic                    es_gr_we,
  input  logic [4:0]              es_dest,
  input  logic                    data_sram_data_ok,
  input  logic [31:0]             data_sram_rdata,
  output logic                    ms2ws_valid,
  input  logic                    ws_allowin,
  output logic [31:0]             ms_pc,
  output logic                    ms_gr_we,
  output logic [4:0]              ms_dest,
  output logic [31:0]             ms_final_result,
  output logic [MS_FWD_BUS_W-1:0] ms_fwd_bus
);

  ms_state_t   state, state_nxt;
  ms_payload_t pl;
  logic        ms_valid;
  logic        ms_ready_go;
  logic        accept;
  logic [31:0] hold_data;
  logic [31:0] load_src;
  logic [31:0] aligned;

  assign accept      = es2ms_valid && ms_allowin;
  assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms2ws_valid = ms_valid && ms_ready_go;

  always_comb begin
    ms_ready_go = 1'b1;
    state_nxt   = state;
    case (state)
      MS_IDLE: begin
        if (accept && es_mem_req) state_nxt = MS_WAIT;
      end
      MS_WAIT: begin
        ms_ready_go = data_sram_data_ok;
        if (data_sram_data_ok) begin
          if (ws_allowin) state_nxt = (accept && es_mem_req) ? MS_WAIT : MS_IDLE;
          else            state_nxt = MS_HOLD;
        end
      end
      MS_HOLD: begin
        if (ws_allowin) state_nxt = (accept && es_mem_req) ? MS_WAIT : MS_IDLE;
      end
      default: state_nxt = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= MS_IDLE;
      ms_valid  <= 1'b0;
      pl        <= '0;
      hold_data <= 32'd0;
    end else begin
      state <= state_nxt;
      if (ms_allowin) ms_valid <= es2ms_valid;
      if (accept) begin
        pl.pc           <= es_pc;
        pl.alu_result   <= es_alu_result;
        pl.res_from_mem <= es_res_from_mem;
        pl.load_op      <= es_load_op;
        pl.gr_we        <= es_gr_we;
        pl.dest         <= es_dest;
      end
      if (state == MS_WAIT && data_sram_data_ok && !ws_allowin) hold_data <= data_sram_rdata;
    end
  end

  // data_ok outside WAIT is never used: rdata is only consumed live in WAIT.
  assign load_src = (state == MS_HOLD) ? hold_data : data_sram_rdata;

  mem_load_align u_align (
    .rdata   (load_src),
    .addr    (pl.alu_result[1:0]),
    .load_op (pl.load_op),
    .result  (aligned)
  );

  assign ms_pc           = pl.pc;
  assign ms_gr_we        = pl.gr_we;
  assign ms_dest         = pl.dest;
  assign ms_final_result = pl.res_from_mem ? aligned : pl.alu_result;

`ifdef MS_FWD_EN
  assign ms_fwd_bus = {ms_valid && pl.res_from_mem && !ms_ready_go,
                       ms_valid && pl.gr_we,
                       pl.dest,
                       ms_final_result};
`else
  assign ms_fwd_bus = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic vs a transaction model.
module tb_mem_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        es2ms_valid, ms_allowin;
  logic [31:0] es_pc, es_alu_result;
  logic        es_res_from_mem, es_mem_req, es_gr_we;
  logic [2:0]  es_load_op;
  logic [4:0]  es_dest;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ms2ws_valid, ws_allowin;
  logic [31:0] ms_pc, ms_final_result;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [MS_FWD_BUS_W-1:0] ms_fwd_bus;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset), .es2ms_valid(es2ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_alu_result(es_alu_result), .es_res_from_mem(es_res_from_mem),
    .es_mem_req(es_mem_req), .es_load_op(es_load_op), .es_gr_we(es_gr_we), .es_dest(es_dest),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ms2ws_valid(ms2ws_valid), .ws_allowin(ws_allowin), .ms_pc(ms_pc), .ms_gr_we(ms_gr_we),
    .ms_dest(ms_dest), .ms_final_result(ms_final_result), .ms_fwd_bus(ms_fwd_bus)
  );

  // Transaction model: the instruction occupying MEM and what is known about its response.
  bit          occ;
  logic [31:0] m_pc, m_alu, m_hold;
  bit          m_res, m_mem, m_we, m_got;
  logic [2:0]  m_op;
  logic [4:0]  m_dest;

  function automatic logic [31:0] align(input logic [31:0] d, input logic [1:0] a, input logic [2:0] op);
    int v;
    if (op == LD_B || op == LD_BU) begin
      v = int'((d >> (8 * a)) % 256);
      if (op == LD_B && v >= 128) v = v - 256;
      return 32'(v);
    end
    if (op == LD_H || op == LD_HU) begin
      v = int'((d >> (16 * a[1])) % 65536);
      if (op == LD_H && v >= 32768) v = v - 65536;
      return 32'(v);
    end
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin : model_update
    bit rdy, al;
    if (reset) begin
      occ = 0; m_pc = 0; m_alu = 0; m_res = 0; m_mem = 0; m_we = 0;
      m_got = 0; m_op = 0; m_dest = 0; m_hold = 0;
    end else begin
      rdy = occ && (!m_mem || m_got || data_sram_data_ok);
      al  = !occ || (rdy && ws_allowin);
      if (occ && m_mem && !m_got && data_sram_data_ok && !ws_allowin) begin
        m_got  = 1;
        m_hold = data_sram_rdata;
      end
      if (al) begin
        occ = es2ms_valid;
        if (es2ms_valid) begin
          m_pc = es_pc; m_alu = es_alu_result; m_res = es_res_from_mem; m_mem = es_mem_req;
          m_op = es_load_op; m_we = es_gr_we; m_dest = es_dest; m_got = 0;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    bit rdy;
    logic [31:0] exp_final;
    if (chk_en) begin
      assert (!(data_sram_data_ok && !reset) || (occ && m_mem && !m_got))
        else $error("data_ok driven with no response outstanding");
      rdy = occ && (!m_mem || m_got || data_sram_data_ok);
      exp_final = m_res ? align(m_got ? m_hold : data_sram_rdata, m_alu[1:0], m_op) : m_alu;
      chk("ms2ws_valid", 32'(ms2ws_valid), 32'(rdy));
      chk("ms_allowin", 32'(ms_allowin), 32'(!occ || (rdy && ws_allowin)));
      chk("ms_pc", ms_pc, m_pc);
      chk("ms_gr_we", 32'(ms_gr_we), 32'(m_we));
      chk("ms_dest", 32'(ms_dest), 32'(m_dest));
      if (!m_res || rdy) chk("ms_final_result", ms_final_result, exp_final);
`ifdef MS_FWD_EN
      chk("fwd_ctrl", 32'(ms_fwd_bus[38:32]), 32'({occ && m_res && !rdy, occ && m_we, m_dest}));
      if (!m_res || rdy) chk("fwd_data", ms_fwd_bus[31:0], exp_final);
`else
      chk("fwd_tied", ms_fwd_bus[31:0] | 32'(ms_fwd_bus[38:32]), 32'd0);
`endif
    end
  end

  task automatic drv(input bit v, input logic [31:0] pc, input logic [31:0] alu, input bit res,
                     input bit req, input logic [2:0] op, input bit we, input logic [4:0] dst,
                     input bit wsa, input bit dok, input logic [31:0] rd);
    es2ms_valid = v; es_pc = pc; es_alu_result = alu; es_res_from_mem = res; es_mem_req = req;
    es_load_op = op; es_gr_we = we; es_dest = dst; ws_allowin = wsa;
    data_sram_data_ok = dok; data_sram_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit wsa);
    drv(0, 0, 0, 0, 0, LD_W, 0, 0, wsa, 0, 32'h0);
  endtask

  initial begin
    int rst_left;
    int kind;
    bit waiting;
    reset = 1;
    idle(1);
    tick();
    chk_en = 1;
    tick();
    reset = 0;

    // Reset held two cycles while a load waits.
    drv(1, 32'h1C000100, 32'h1C002000, 1, 1, LD_W, 1, 5'd7, 1, 0, 32'h0);
    tick();
    idle(1);
    reset = 1;
    tick();
    tick();
    reset = 0;
    @(negedge clk);
    chk("rst_valid", 32'(ms2ws_valid), 32'd0);
    chk("rst_allowin", 32'(ms_allowin), 32'd1);
    chk("rst_pc", ms_pc, 32'd0);
    chk("rst_dest", 32'(ms_dest), 32'd0);
    chk("rst_we", 32'(ms_gr_we), 32'd0);
    chk("rst_final", ms_final_result, 32'd0);

    // ALU op: one-cycle latency.
    drv(1, 32'h1C000000, 32'h12345678, 0, 0, LD_W, 1, 5'd3, 1, 0, 32'h0);
    tick();
    idle(1);
    @(negedge clk);
    chk("alu_valid", 32'(ms2ws_valid), 32'd1);
    chk("alu_final", ms_final_result, 32'h12345678);
    chk("alu_pc", ms_pc, 32'h1C000000);
    tick();

    // LD_B at lane 3, then LD_HU at lane 2, response three cycles after acceptance.
    for (int t = 0; t < 2; t++) begin
      drv(1, 32'h1C000010, t == 0 ? 32'h1C001003 : 32'h1C001002, 1, 1,
          t == 0 ? LD_B : LD_HU, 1, 5'd9, 1, 0, 32'h0);
      tick();
      for (int w = 0; w < 2; w++) begin
        idle(1);
        @(negedge clk);
        chk("ld_wait_allowin", 32'(ms_allowin), 32'd0);
        chk("ld_wait_valid", 32'(ms2ws_valid), 32'd0);
`ifdef MS_FWD_EN
        chk("fwd_blocking", 32'(ms_fwd_bus[38]), 32'd1);
`endif
        tick();
      end
      drv(0, 0, 0, 0, 0, LD_W, 0, 0, 1, 1, 32'h80FF00AA);
      @(negedge clk);
      chk("ld_valid", 32'(ms2ws_valid), 32'd1);
      chk("ld_final", ms_final_result, t == 0 ? 32'hFFFFFF80 : 32'h000080FF);
`ifdef MS_FWD_EN
      chk("fwd_unblock", 32'(ms_fwd_bus[38]), 32'd0);
      chk("fwd_aligned", ms_fwd_bus[31:0], t == 0 ? 32'hFFFFFF80 : 32'h000080FF);
`endif
      tick();
    end

    // LD_W response while WB stalls; rdata bus moves on afterwards.
    drv(1, 32'h1C000020, 32'h1C003000, 1, 1, LD_W, 1, 5'd4, 0, 0, 32'h0);
    tick();
    drv(0, 0, 0, 0, 0, LD_W, 0, 0, 0, 1, 32'hCAFEF00D);
    tick();
    for (int w = 0; w < 4; w++) begin
      drv(0, 0, 0, 0, 0, LD_W, 0, 0, 0, 0, 32'h11111111 * (w + 1));
      @(negedge clk);
      chk("hold_final", ms_final_result, 32'hCAFEF00D);
      chk("hold_allowin", 32'(ms_allowin), 32'd0);
      tick();
    end
    drv(0, 0, 0, 0, 0, LD_W, 0, 0, 1, 0, 32'h55555555);
    @(negedge clk);
    chk("hold_handoff", ms_final_result, 32'hCAFEF00D);
    chk("hold_valid", 32'(ms2ws_valid), 32'd1);
    tick();

    // Back-to-back loads, a response every cycle.
    drv(1, 32'h1C000100, 32'h1C004000, 1, 1, LD_W, 1, 5'd1, 1, 0, 32'h0);
    tick();
    for (int k = 1; k <= 8; k++) begin
      drv(k < 8, 32'h1C000100 + 4 * k, 32'h1C004000 + 4 * k, 1, 1, LD_W, 1, 5'(k + 1),
          1, 1, 32'hA0000000 + k);
      @(negedge clk);
      chk("b2b_valid", 32'(ms2ws_valid), 32'd1);
      chk("b2b_allowin", 32'(ms_allowin), 32'd1);
      tick();
    end
    idle(1);
    tick();

    // Randomized traffic.
    rst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rst_left == 0 && $urandom_range(0, 249) == 0) rst_left = 2;
      reset = (rst_left != 0);
      if (rst_left != 0) rst_left--;
      kind = $urandom_range(0, 2);
      waiting = occ && m_mem && !m_got;
      drv($urandom_range(0, 99) < 60, $urandom, $urandom, kind == 1, kind != 0,
          3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
          $urandom_range(0, 99) < 70, waiting && !reset && ($urandom_range(0, 99) < 40),
          $urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
